ecall_unit: RTL and testbench
=============================

Name: ecall_unit

Overview:
Services the environment-call stall raised by the instruction decode controller. It holds the core in ecall wait, executes the requested service against board I/O (switches, confirm button, display register), and returns a one-cycle EcallDone pulse that releases the controller's wait latch. Service results are written back to x10 (a0) through a dedicated register-file write port.

Parameters:
SW_WIDTH, 16, width of the switch input bus.
DEBOUNCE_CYCLES, 1000000, number of consecutive stable samples needed before the confirm button's debounced level changes.
DB_CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
Ecall  in  1  controller ecall request (ecall opcode or wait latch).
a7  in  32  current x17 value: service code.
a0  in  32  current x10 value: service argument.
sw  in  SW_WIDTH  raw board switches.
btn_confirm  in  1  raw confirm button, asynchronous.
EcallDone  out  1  one-cycle completion pulse to the controller.
EcallRegWrite  out  1  write-back enable, valid with EcallDone.
EcallWriteReg  out  5  write-back register index, constant 5'd10.
EcallWriteData  out  32  write-back data.
disp_value  out  32  value latched for the 7-segment/LED display.
disp_valid  out  1  set by the first print service, held until reset.
busy  out  1  high in every state except IDLE.
halted  out  1  high in HALT.

Behaviour:
- Reset (rst=1 at an edge, including mid-service): state becomes IDLE, all outputs 0 (EcallWriteReg stays 10), synchronizer and debounce state cleared. Reset overrides every other event.
- Button path:
  - 2-flop synchronizer, then a counter. The counter increments while the synchronized level differs from the debounced level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - confirm = 1-cycle pulse on the debounced rising edge. Release is never an event.
- FSM states: IDLE, PRINT_WAIT, READ_WAIT, DONE, RELEASE, HALT.
- IDLE with Ecall=1: sample a7 and a0 at the edge, then go by a7[7:0]:
  - 1 (print int): disp_value<=a0, disp_valid<=1, go to PRINT_WAIT.
  - 5 (read unsigned): go to READ_WAIT, mode zero-extend.
  - 12 (read signed): go to READ_WAIT, mode sign-extend from bit SW_WIDTH-1.
  - 10 (exit): go to HALT.
  - Any other code: go to DONE, no write-back.
- PRINT_WAIT: on confirm go to DONE, no write-back.
- READ_WAIT: on confirm, capture sw (extended per mode) into EcallWriteData, arm write-back, go to DONE. The switch value is taken in the confirm cycle, not at ecall entry.
- A confirm pulse that occurs in IDLE is discarded. It is never banked for a later service.
- DONE: EcallDone=1 for exactly this cycle. EcallRegWrite=1 in this cycle only if write-back is armed. Next state RELEASE.
- RELEASE: Ecall is ignored for this one cycle so the controller clears its wait latch and the PC advances. Next state IDLE.
  - Net effect: a back-to-back ecall is accepted no earlier than 2 cycles after EcallDone.
- HALT: absorbing. EcallDone is never asserted, so the core remains stalled. Only rst exits.
- Latency: an unknown code gives EcallDone exactly 1 cycle after the accepting edge. Print and read give EcallDone 1 cycle after the confirm pulse.
- Ecall dropping while in a WAIT state (e.g. a branch flush) does not abort the service. The service completes and the EcallDone pulse is harmless to the controller.
- EcallWriteData holds its value between services. Consumers gate on EcallRegWrite.

Test Plan:
1. DEBOUNCE_CYCLES=4; a7=1, a0=32'hDEADBEEF, Ecall=1 -> disp_value=DEADBEEF and disp_valid=1 next cycle, busy=1; press button (held 10 cycles) -> single EcallDone, EcallRegWrite=0, then idle 2 cycles later.
2. a7=5, sw=16'hF00F, press -> EcallDone with EcallRegWrite=1, EcallWriteReg=10, EcallWriteData=32'h0000F00F; with a7=12 -> 32'hFFFFF00F.
3. Button bounce: toggle btn_confirm every cycle for 3 cycles before holding high -> exactly one confirm; glitch shorter than 4 cycles -> no EcallDone.
4. a7=99 -> EcallDone exactly 1 cycle after acceptance, no write; Ecall held high continuously -> second acceptance no earlier than 2 cycles after first EcallDone.
5. a7=10 -> halted=1, EcallDone never asserts over 100 cycles even with button presses; rst=1 -> halted=0, state IDLE.
6. rst asserted in READ_WAIT with button pressed -> no EcallDone, all outputs 0, next Ecall serviced normally.

Source files
------------

// File: rtl/ecall_unit.sv
// Environment-call service unit: stalls the core while print/read/exit services
// run against board I/O, then pulses EcallDone and optionally writes back x10.
module ecall_unit #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_CNT_W        = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Ecall,
    input  logic [31:0]         a7,
    input  logic [31:0]         a0,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                btn_confirm,
    output logic                EcallDone,
    output logic                EcallRegWrite,
    output logic [4:0]          EcallWriteReg,
    output logic [31:0]         EcallWriteData,
    output logic [31:0]         disp_value,
    output logic                disp_valid,
    output logic                busy,
    output logic                halted
);

    typedef enum logic [2:0] {
        IDLE, PRINT_WAIT, READ_WAIT, DONE, RELEASE, HALT
    } state_t;

    state_t                state_q;
    logic                  sync1_q, sync2_q, db_level_q, confirm_q;
    logic [DB_CNT_W-1:0]   db_cnt_q;
    logic                  done_q, regwr_q, sext_q, disp_valid_q, busy_q, halted_q;
    logic [31:0]           wdata_q, disp_value_q;
    logic [31:0]           sw_ext;
    logic                  unused_a7;

    // Only the low byte of a7 selects a service.
    assign unused_a7 = ^a7[31:8];

    assign sw_ext = sext_q ? {{(32-SW_WIDTH){sw[SW_WIDTH-1]}}, sw}
                           : {{(32-SW_WIDTH){1'b0}}, sw};

    // Button: 2-flop synchronizer, stability counter, rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            confirm_q  <= 1'b0;
        end else begin
            sync1_q   <= btn_confirm;
            sync2_q   <= sync1_q;
            confirm_q <= 1'b0;
            if (sync2_q != db_level_q) begin
                if (db_cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level_q <= sync2_q;
                    db_cnt_q   <= '0;
                    confirm_q  <= sync2_q;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            regwr_q      <= 1'b0;
            sext_q       <= 1'b0;
            wdata_q      <= '0;
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            regwr_q <= 1'b0;
            case (state_q)
                IDLE: if (Ecall) begin
                    busy_q <= 1'b1;
                    case (a7[7:0])
                        8'd1: begin
                            disp_value_q <= a0;
                            disp_valid_q <= 1'b1;
                            state_q      <= PRINT_WAIT;
                        end
                        8'd5: begin
                            sext_q  <= 1'b0;
                            state_q <= READ_WAIT;
                        end
                        8'd12: begin
                            sext_q  <= 1'b1;
                            state_q <= READ_WAIT;
                        end
                        8'd10: begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                        default: begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    endcase
                end
                PRINT_WAIT: if (confirm_q) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                READ_WAIT: if (confirm_q) begin
                    wdata_q <= sw_ext;
                    done_q  <= 1'b1;
                    regwr_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= RELEASE;
                // One blind cycle so the controller can drop its wait latch.
                RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign EcallDone      = done_q;
    assign EcallRegWrite  = regwr_q;
    assign EcallWriteReg  = 5'd10;
    assign EcallWriteData = wdata_q;
    assign disp_value     = disp_value_q;
    assign disp_valid     = disp_valid_q;
    assign busy           = busy_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_ecall_unit.sv
// Scoreboarded bench for ecall_unit with a short debounce window.
module tb_ecall_unit;

    logic        clk = 1'b0;
    logic        rst, Ecall, btn_confirm;
    logic [31:0] a7, a0;
    logic [15:0] sw;
    logic        EcallDone, EcallRegWrite, disp_valid, busy, halted;
    logic [4:0]  EcallWriteReg;
    logic [31:0] EcallWriteData, disp_value;

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   base;

    always #5 clk = ~clk;

    ecall_unit #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(4), .DB_CNT_W(3)) dut (
        .clk(clk), .rst(rst), .Ecall(Ecall), .a7(a7), .a0(a0), .sw(sw),
        .btn_confirm(btn_confirm), .EcallDone(EcallDone),
        .EcallRegWrite(EcallRegWrite), .EcallWriteReg(EcallWriteReg),
        .EcallWriteData(EcallWriteData), .disp_value(disp_value),
        .disp_valid(disp_valid), .busy(busy), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic wr, input logic [31:0] data);
        exp_t e;
        e.wr = wr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Ends at the negedge inside the DONE cycle, or records a timeout.
    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (EcallDone) seen = 1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_done"},  {31'd0, EcallDone}, 0);
        chk({tag, "_rw"},    {31'd0, EcallRegWrite}, 0);
        chk({tag, "_wreg"},  {27'd0, EcallWriteReg}, 10);
        chk({tag, "_wdata"}, EcallWriteData, 0);
        chk({tag, "_disp"},  disp_value, 0);
        chk({tag, "_dval"},  {31'd0, disp_valid}, 0);
        chk({tag, "_busy"},  {31'd0, busy}, 0);
        chk({tag, "_halt"},  {31'd0, halted}, 0);
    endtask

    task automatic read_svc(input logic [7:0] code, input logic [15:0] val,
                            input logic [31:0] exp, input string tag);
        a7 = {24'd0, code}; sw = 16'h0000; Ecall = 1;
        tick(1);
        Ecall = 0;
        push_exp(1'b1, exp);
        tick(2);
        sw = val;                      // switches change after entry
        btn_confirm = 1;
        wait_done(tag);
        tick(1);
        btn_confirm = 0;
        tick(10);
    endtask

    // Scoreboard: every EcallDone pulse consumes one expected write-back.
    always @(negedge clk) begin
        if (EcallDone) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_regwrite", {31'd0, EcallRegWrite}, {31'd0, mon_e.wr});
                chk("sb_wreg", {27'd0, EcallWriteReg}, 10);
                if (mon_e.wr) chk("sb_wdata", EcallWriteData, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1; Ecall = 0; a7 = 0; a0 = 0; sw = 0; btn_confirm = 0;
        tick(3);
        chk_reset_state("rst");
        rst = 0;
        tick(2);

        // Print service, button held 10 cycles.
        a7 = 1; a0 = 32'hDEADBEEF; Ecall = 1;
        tick(1);
        Ecall = 0;
        chk("print_disp", disp_value, 32'hDEADBEEF);
        chk("print_dval", {31'd0, disp_valid}, 1);
        chk("print_busy", {31'd0, busy}, 1);
        push_exp(1'b0, 0);
        base = done_cnt;
        btn_confirm = 1;
        wait_done("print_done");
        tick(1);
        chk("release_busy", {31'd0, busy}, 1);
        tick(1);
        chk("idle_busy", {31'd0, busy}, 0);
        tick(3);
        btn_confirm = 0;
        tick(10);
        chk("print_one_done", done_cnt - base, 1);

        // Read services.
        read_svc(8'd5,  16'hF00F, 32'h0000F00F, "read_u");
        read_svc(8'd12, 16'hF00F, 32'hFFFFF00F, "read_s");
        read_svc(8'd12, 16'h7FFF, 32'h00007FFF, "read_s_pos");

        // Bouncing press yields exactly one confirm.
        a7 = 5; sw = 16'h1234; Ecall = 1;
        tick(1);
        Ecall = 0;
        push_exp(1'b1, 32'h00001234);
        base = done_cnt;
        btn_confirm = 1; tick(1);
        btn_confirm = 0; tick(1);
        btn_confirm = 1; tick(1);
        wait_done("bounce_done");
        tick(8);
        btn_confirm = 0;
        tick(10);
        chk("bounce_one_done", done_cnt - base, 1);

        // Short glitch is filtered; the print then completes on a real press.
        a7 = 1; a0 = 32'h0000_00AA; Ecall = 1;
        tick(1);
        Ecall = 0;
        push_exp(1'b0, 0);
        base = done_cnt;
        btn_confirm = 1; tick(3);
        btn_confirm = 0; tick(15);
        chk("glitch_no_done", done_cnt - base, 0);
        chk("glitch_busy", {31'd0, busy}, 1);
        btn_confirm = 1;
        wait_done("glitch_then_done");
        tick(1);
        btn_confirm = 0;
        tick(10);

        // Unknown code with Ecall held: exact latency and re-accept spacing.
        push_exp(1'b0, 0);
        push_exp(1'b0, 0);
        a7 = 99; Ecall = 1;
        tick(1);
        chk("unk_done_t1", {31'd0, EcallDone}, 1);
        chk("unk_rw_t1", {31'd0, EcallRegWrite}, 0);
        tick(1);
        chk("unk_done_t2", {31'd0, EcallDone}, 0);
        tick(1);
        chk("unk_done_t3", {31'd0, EcallDone}, 0);
        chk("unk_busy_t3", {31'd0, busy}, 0);
        tick(1);
        chk("unk_done_t4", {31'd0, EcallDone}, 1);
        Ecall = 0;
        tick(5);

        // Exit halts permanently, even with presses and Ecall high.
        a7 = 10; Ecall = 1;
        tick(1);
        base = done_cnt;
        chk("halt_flag", {31'd0, halted}, 1);
        repeat (5) begin
            btn_confirm = 1; tick(10);
            btn_confirm = 0; tick(10);
        end
        chk("halt_no_done", done_cnt - base, 0);
        chk("halt_busy", {31'd0, busy}, 1);
        chk("halt_still", {31'd0, halted}, 1);
        Ecall = 0;
        rst = 1;
        tick(1);
        rst = 0;
        tick(1);
        chk("halt_rst_halted", {31'd0, halted}, 0);
        chk("halt_rst_busy", {31'd0, busy}, 0);

        // Reset mid-read with button pressed; a confirm landing in IDLE is dropped.
        a7 = 5; sw = 16'h5555; Ecall = 1;
        tick(1);
        Ecall = 0;
        base = done_cnt;
        btn_confirm = 1;
        tick(5);
        rst = 1;
        tick(2);
        chk_reset_state("midrst");
        rst = 0;
        tick(12);
        chk("midrst_no_done", done_cnt - base, 0);
        chk("midrst_idle", {31'd0, busy}, 0);
        btn_confirm = 0;
        tick(10);
        a7 = 5; sw = 16'h00AB; Ecall = 1;
        tick(1);
        Ecall = 0;
        push_exp(1'b1, 32'h000000AB);
        tick(10);
        chk("not_banked", done_cnt - base, 0);
        btn_confirm = 1;
        wait_done("after_rst_done");
        tick(1);
        btn_confirm = 0;
        tick(10);

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
